prog_interval_timer: RTL
========================

Name: prog_interval_timer

Overview:
- 16-bit programmable down-counting interval timer on the CPU's 8-bit peripheral bus.
- Its irq output drives one request input (in0..in7) of the interrupt controller directly downstream. That controller rising-edge-detects its inputs, so irq is a level that stays high until software clears it.
- Supports one-shot and periodic modes, a selectable prescaler, and a tear-free 16-bit count readback.

Parameters:
- PRE1, 16, prescale divisor for psel=01 (power of two, 2..4096)
- PRE2, 256, prescale divisor for psel=10 (power of two, 2..4096)
- PRE3, 4096, prescale divisor for psel=11 (power of two, 2..4096)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ce  in  1  peripheral select, one-cycle bus access
- wren  in  1  write strobe, qualified by ce
- addr  in  3  register select
- from_cpu  in  8  write data
- to_cpu  out  8  read data, registered
- irq  out  1  interrupt request level to the interrupt controller

Behaviour:
- Registers:
  - 0: RELOAD_L, rw
  - 1: RELOAD_H, rw
  - 2: CTRL, rw. bit0 en, bit1 periodic, bit2 irq_en, bits4:3 psel, bits7:5 read 0.
  - 3: STATUS. bit0 expired (W1C), bit1 running (ro), bit2 overrun (W1C), others read 0.
  - 4: COUNT_L, ro. A read also latches count[15:8] into cnt_hi_latch.
  - 5: COUNT_H, ro. Returns cnt_hi_latch.
  - 6, 7: read 0, writes ignored.
- Reads: when ce=1, to_cpu is loaded at the next clk edge (1-cycle latency). Otherwise to_cpu holds. This applies to both read and write cycles.
- Reset (rst=0, async): reload=0, ctrl=0, count=0, prescaler=0, expired=0, overrun=0, running=0, cnt_hi_latch=0, to_cpu=0, irq=0.
- Start: a CTRL write with en=1 while running=0 sets running, loads count<=reload and clears the prescaler on the same edge.
  - A CTRL write with en=1 while already running updates periodic/irq_en/psel only. No restart, count and prescaler are untouched.
- Stop: a CTRL write with en=0 clears running. Count and prescaler freeze; expired is unaffected.
- Tick:
  - psel=00: every cycle while running.
  - Otherwise: prescaler (12-bit) increments each running cycle; tick when it equals divisor-1, then it wraps to 0.
  - psel changes apply from the current prescaler value, using the new compare.
- On each tick:
  - count!=0: count<=count-1.
  - count==0: expiry event.
    - If expired was already 1, overrun<=1.
    - expired<=1.
    - periodic=1: count<=reload.
    - periodic=0: running<=0 and CTRL.en<=0.
- Period: expired rises on the (reload+1)th tick after start. reload=0 with psel=00 periodic expires every cycle.
- RELOAD writes never alter count directly; the new value is used at the next start or periodic reload.
- STATUS write: bits set in from_cpu clear expired/overrun. An expiry event in the same cycle wins: the bit ends 1, and overrun follows the pre-write expired.
- Start and expiry in the same cycle cannot occur (start requires running=0).
- irq is registered: irq<=expired_next & irq_en_next. It deasserts the cycle after expired is cleared or irq_en is cleared. A fresh expiry after clear gives a new rising edge for the controller.
- Mid-operation reset: all state returns to reset values immediately, irq drops asynchronously, counting stops.

Test Plan:
- One-shot:
  - Stimulus: reload=0x0003, CTRL=0x05 (en, irq_en, psel 00).
  - Required: expired and irq rise 4 cycles after the start edge; running=0; CTRL reads 0x04; count stays 0.
- Periodic with prescale:
  - Stimulus: reload=1, CTRL=0x0B (en, periodic, psel 01, PRE1=16); leave irq_en=0.
  - Required: expiry every 32 cycles; irq stays 0; after the second expiry without clearing, STATUS reads 0x07.
- W1C vs expiry:
  - Stimulus: periodic reload=0, psel 00 (expiry every cycle); write STATUS=0x01.
  - Required: expired remains 1 (set wins), overrun=1.
  - Stimulus: then stop and write 0x05.
  - Required: STATUS reads 0x00, irq falls the next cycle.
- Atomic count read:
  - Stimulus: reload=0x0100, running, psel 00; read COUNT_L when count=0x0100, then COUNT_H 3 cycles later.
  - Required: data 0x00 then 0x01 (latched), not the live high byte.
- Stop/restart:
  - Stimulus: write en=0 mid-count, wait 10 cycles.
  - Required: count unchanged.
  - Stimulus: change reload to 5, write en=1 while stopped.
  - Required: count reloads 5.
  - Stimulus: write en=1 while running.
  - Required: count continues without reload.
- Async reset:
  - Stimulus: assert rst=0 mid-count with irq=1, between clk edges.
  - Required: irq, to_cpu, STATUS go 0 immediately; after release, CTRL reads 0x00 and no ticks occur.

Source files
------------

// File: rtl/prog_interval_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : prog_interval_timer
// Description : 16-bit programmable down-counting interval timer with prescaler,
//               one-shot/periodic modes and tear-free count readback.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_interval_timer #(
    parameter int PRE1 = 16,
    parameter int PRE2 = 256,
    parameter int PRE3 = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       wren,
    input  logic [2:0] addr,
    input  logic [7:0] from_cpu,
    output logic [7:0] to_cpu,
    output logic       irq
);

    localparam logic [2:0]  c_ADDR_RELOAD_L = 3'd0;
    localparam logic [2:0]  c_ADDR_RELOAD_H = 3'd1;
    localparam logic [2:0]  c_ADDR_CTRL     = 3'd2;
    localparam logic [2:0]  c_ADDR_STATUS   = 3'd3;
    localparam logic [2:0]  c_ADDR_COUNT_L  = 3'd4;
    localparam logic [2:0]  c_ADDR_COUNT_H  = 3'd5;
    localparam logic [11:0] c_CMP1          = 12'(PRE1 - 1);
    localparam logic [11:0] c_CMP2          = 12'(PRE2 - 1);
    localparam logic [11:0] c_CMP3          = 12'(PRE3 - 1);

    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic [11:0] r_pre;
    logic        r_running;
    logic        r_periodic;
    logic        r_irq_en;
    logic [1:0]  r_psel;
    logic        r_expired;
    logic        r_overrun;
    logic [7:0]  r_cnt_hi_latch;
    logic [7:0]  r_to_cpu;
    logic        r_irq;

    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_stat_wr;
    logic        w_start;
    logic        w_stop;
    logic        w_active;
    logic [11:0] w_cmp;
    logic        w_tick;
    logic        w_expiry;
    logic        w_expired_nxt;
    logic        w_overrun_nxt;
    logic        w_irq_en_nxt;
    logic [7:0]  w_rdata;

    assign w_wr      = ce & wren;
    assign w_rd      = ce & ~wren;
    assign w_ctrl_wr = w_wr & (addr == c_ADDR_CTRL);
    assign w_stat_wr = w_wr & (addr == c_ADDR_STATUS);
    assign w_start   = w_ctrl_wr & from_cpu[0] & ~r_running;
    assign w_stop    = w_ctrl_wr & ~from_cpu[0];
    // A stop write freezes count and prescaler from its own edge onward.
    assign w_active  = r_running & ~w_stop;

    always_comb begin
        w_cmp = c_CMP1;
        case (r_psel)
            2'b01:   w_cmp = c_CMP1;
            2'b10:   w_cmp = c_CMP2;
            2'b11:   w_cmp = c_CMP3;
            default: w_cmp = c_CMP1;
        endcase
    end

    assign w_tick   = w_active & ((r_psel == 2'b00) | (r_pre == w_cmp));
    assign w_expiry = w_tick & (r_count == 16'd0);

    // Expiry takes precedence over a same-cycle W1C clear.
    assign w_expired_nxt = w_expiry ? 1'b1
                         : (w_stat_wr & from_cpu[0]) ? 1'b0 : r_expired;
    assign w_overrun_nxt = (w_expiry & r_expired) ? 1'b1
                         : (w_stat_wr & from_cpu[2]) ? 1'b0 : r_overrun;
    assign w_irq_en_nxt  = w_ctrl_wr ? from_cpu[2] : r_irq_en;

    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            c_ADDR_RELOAD_L: w_rdata = r_reload[7:0];
            c_ADDR_RELOAD_H: w_rdata = r_reload[15:8];
            c_ADDR_CTRL:     w_rdata = {3'b000, r_psel, r_irq_en, r_periodic, r_running};
            c_ADDR_STATUS:   w_rdata = {5'b00000, r_overrun, r_running, r_expired};
            c_ADDR_COUNT_L:  w_rdata = r_count[7:0];
            c_ADDR_COUNT_H:  w_rdata = r_cnt_hi_latch;
            default:         w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reload       <= 16'd0;
            r_count        <= 16'd0;
            r_pre          <= 12'd0;
            r_running      <= 1'b0;
            r_periodic     <= 1'b0;
            r_irq_en       <= 1'b0;
            r_psel         <= 2'b00;
            r_expired      <= 1'b0;
            r_overrun      <= 1'b0;
            r_cnt_hi_latch <= 8'd0;
            r_to_cpu       <= 8'd0;
            r_irq          <= 1'b0;
        end else begin
            if (w_wr && addr == c_ADDR_RELOAD_L) r_reload[7:0]  <= from_cpu;
            if (w_wr && addr == c_ADDR_RELOAD_H) r_reload[15:8] <= from_cpu;

            if (w_ctrl_wr) begin
                r_periodic <= from_cpu[1];
                r_irq_en   <= from_cpu[2];
                r_psel     <= from_cpu[4:3];
            end

            // The CTRL en bit reads back as r_running, so both clear together.
            if (w_stop || (w_expiry && !r_periodic))
                r_running <= 1'b0;
            else if (w_start)
                r_running <= 1'b1;

            if (w_start)
                r_count <= r_reload;
            else if (w_tick) begin
                if (r_count != 16'd0)
                    r_count <= r_count - 16'd1;
                else if (r_periodic)
                    r_count <= r_reload;
            end

            if (w_start)
                r_pre <= 12'd0;
            else if (w_active && r_psel != 2'b00)
                r_pre <= (r_pre == w_cmp) ? 12'd0 : r_pre + 12'd1;

            r_expired <= w_expired_nxt;
            r_overrun <= w_overrun_nxt;
            r_irq     <= w_expired_nxt & w_irq_en_nxt;

            if (w_rd && addr == c_ADDR_COUNT_L) r_cnt_hi_latch <= r_count[15:8];
            if (ce) r_to_cpu <= w_rdata;
        end
    end

    assign to_cpu = r_to_cpu;
    assign irq    = r_irq;

endmodule
`default_nettype wire
